// File: rtl/drop_tick_receiver_if.sv
// Drop-tick receiver bus: divided-clock taps and controls in, handshaked tick and miss count out.
interface drop_tick_receiver_if #(
   parameter int unsigned CNT_W = 4
);
   logic             tap_slow;
   logic             tap_fast;
   logic             enable;
   logic             fast_sel;
   logic             tick_ack;
   logic             clear_missed;
   logic             tick_req;
   logic             busy;
   logic [CNT_W-1:0] missed;

   modport master (
      output tap_slow, tap_fast, enable, fast_sel, tick_ack, clear_missed,
      input  tick_req, busy, missed
   );

   modport slave (
      input  tap_slow, tap_fast, enable, fast_sel, tick_ack, clear_missed,
      output tick_req, busy, missed
   );
endinterface

// File: rtl/drop_tick_receiver.sv
// Turns asynchronous slow/fast drop-rate taps into handshaked drop ticks with a missed-tick count.
// Optional feature macro: DROP_TICK_MISS_CNT_EN builds the missed counter and clear_missed logic.
module drop_tick_receiver #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   drop_tick_receiver_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

   localparam int unsigned MSB = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0] sync_slow;
   logic [SYNC_STAGES-1:0] sync_fast;
   logic                   hist_slow;
   logic                   hist_fast;
   logic                   edge_slow;
   logic                   edge_fast;
   logic                   sel_edge;

   state_t state;
   state_t state_nxt;
   logic   miss_inc;
   logic   tick_req_q;
   logic   busy_q;

   // Synchronizer chains plus one history flop per tap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_slow <= '0;
         sync_fast <= '0;
         hist_slow <= 1'b0;
         hist_fast <= 1'b0;
      end else begin
         sync_slow <= {sync_slow[MSB-1:0], bus.tap_slow};
         sync_fast <= {sync_fast[MSB-1:0], bus.tap_fast};
         hist_slow <= sync_slow[MSB];
         hist_fast <= sync_fast[MSB];
      end
   end

   assign edge_slow = sync_slow[MSB] & ~hist_slow;
   assign edge_fast = sync_fast[MSB] & ~hist_fast;
   // Muxing edge pulses, not levels, so a fast_sel flip cannot fabricate an edge
   assign sel_edge  = bus.fast_sel ? edge_fast : edge_slow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         tick_req_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state      <= state_nxt;
         tick_req_q <= (state_nxt == ST_PENDING);
         busy_q     <= (state_nxt != ST_IDLE);
      end
   end

   // Next-state logic; enable low overrides everything and drops a pending tick uncounted
   always_comb begin
      state_nxt = state;
      miss_inc  = 1'b0;
      if (!bus.enable) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:    state_nxt = ST_ARMED;
            ST_ARMED:   if (sel_edge) state_nxt = ST_PENDING;
            ST_PENDING: begin
               if (bus.tick_ack && !sel_edge) begin
                  state_nxt = ST_ARMED;
               end else if (sel_edge && !bus.tick_ack) begin
                  miss_inc = 1'b1;
               end
            end
            default:    state_nxt = ST_IDLE;
         endcase
      end
   end

   assign bus.tick_req = tick_req_q;
   assign bus.busy     = busy_q;

`ifdef DROP_TICK_MISS_CNT_EN
   logic [CNT_W-1:0] missed_q;

   // Saturating miss counter; clear wins over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         missed_q <= '0;
      end else if (bus.clear_missed) begin
         missed_q <= '0;
      end else if (miss_inc && (missed_q != {CNT_W{1'b1}})) begin
         missed_q <= missed_q + CNT_W'(1);
      end
   end

   assign bus.missed = missed_q;
`else
   logic unused_miss_inputs;

   assign unused_miss_inputs = bus.clear_missed ^ miss_inc;
   assign bus.missed         = '0;
`endif

endmodule
